// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response bundle between the execute stage and the mul/div unit
//
// Purpose: groups the muldiv_unit handshake and operand/result signals.
// Signals:
//   start    request strobe, sampled only while the unit is idle
//   alu_ctl  5-bit operation code (11..18), sampled with start
//   a, b     operands rs1/rs2, sampled with start
//   busy     high while an operation is iterating
//   done     one-cycle pulse, result valid in that cycle
//   result   operation result, held until the next accepted op or reset
//   zero     result == 0
// Modports: master = pipeline side, slave = muldiv_unit side.

interface muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [4:0]      alu_ctl;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic            zero;

   modport master (
      output start, alu_ctl, a, b,
      input  busy, done, result, zero
   );

   modport slave (
      input  start, alu_ctl, a, b,
      output busy, done, result, zero
   );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit for alu_ctl codes 11..18
//
// Purpose: computes divu/div/remu/rem (11..14) and mul/mulhu/mulhsu/mulh
// (15..18) over 32 iteration cycles, returning the result with a done pulse.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    muldiv_unit_if slave modport (start/alu_ctl/a/b in,
//          busy/done/result/zero out)
// Timing: start accepted at edge E0; busy is high after edges E1..E32;
// done and the new result are visible after edge E33.

module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_unit_if.slave bus
);

   localparam logic [4:0] OP_DIVU   = 5'd11;
   localparam logic [4:0] OP_DIV    = 5'd12;
   localparam logic [4:0] OP_REMU   = 5'd13;
   localparam logic [4:0] OP_REM    = 5'd14;
   localparam logic [4:0] OP_MUL    = 5'd15;
   localparam logic [4:0] OP_MULHU  = 5'd16;
   localparam logic [4:0] OP_MULHSU = 5'd17;
   localparam logic [4:0] OP_MULH   = 5'd18;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   // Operation context captured at accept time
   logic [4:0]        op_q;
   logic [XLEN-1:0]   opnd_q;    // multiplicand (mul) or divisor (div) magnitude
   logic [2*XLEN-1:0] acc_q;     // mul: {partial hi, multiplier/low}; div: {remainder, quotient}
   logic              neg_q;     // result must be negated in fix-up
   logic              bzero_q;   // divisor was zero
   logic [5:0]        cnt_q;

   logic              busy_q;
   logic              done_q;
   logic [XLEN-1:0]   result_q;

   // ---------------------------------------------------------------
   // Request decode and operand preparation
   // ---------------------------------------------------------------
   logic            valid_op;
   logic            accept;
   logic            is_mul_in;
   logic            is_rem_in;
   logic            sa_in;
   logic            sb_in;
   logic            neg_in;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;

   assign valid_op  = (bus.alu_ctl >= OP_DIVU) && (bus.alu_ctl <= OP_MULH);
   assign accept    = (state == S_IDLE) && bus.start && valid_op;
   assign is_mul_in = (bus.alu_ctl >= OP_MUL);
   assign is_rem_in = (bus.alu_ctl == OP_REMU) || (bus.alu_ctl == OP_REM);

   // mulhsu treats only a as signed
   assign sa_in = bus.a[XLEN-1] &&
                  ((bus.alu_ctl == OP_DIV) || (bus.alu_ctl == OP_REM) ||
                   (bus.alu_ctl == OP_MULHSU) || (bus.alu_ctl == OP_MULH));
   assign sb_in = bus.b[XLEN-1] &&
                  ((bus.alu_ctl == OP_DIV) || (bus.alu_ctl == OP_REM) ||
                   (bus.alu_ctl == OP_MULH));

   // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude
   assign mag_a = sa_in ? -bus.a : bus.a;
   assign mag_b = sb_in ? -bus.b : bus.b;

   // Remainder follows the dividend; everything else follows the sign product
   assign neg_in = is_rem_in ? sa_in : (sa_in ^ sb_in);

   // ---------------------------------------------------------------
   // One iteration step
   // ---------------------------------------------------------------
   logic              is_mul;
   logic              last_iter;
   logic [XLEN:0]     mul_sum;
   logic [XLEN+1:0]   trial;
   logic [2*XLEN-1:0] acc_step;

   assign is_mul    = (op_q >= OP_MUL);
   assign last_iter = (cnt_q == 6'(XLEN-1));

   // Shift-add: add multiplicand into the high half when the current
   // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
   assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

   // Restoring divide: shifted partial remainder {rem, next dividend bit}
   // minus divisor; the extra top bit is the borrow.
   assign trial = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opnd_q};

   always_comb begin
      acc_step = acc_q;
      if (is_mul) begin
         acc_step = {mul_sum, acc_q[XLEN-1:1]};
      end else if (trial[XLEN+1]) begin
         acc_step = {acc_q[2*XLEN-2:0], 1'b0};
      end else begin
         acc_step = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end
   end

   // ---------------------------------------------------------------
   // Sign fix-up and result selection
   // ---------------------------------------------------------------
   logic [2*XLEN-1:0] prod_f;
   logic [XLEN-1:0]   quo_f;
   logic [XLEN-1:0]   rem_f;
   logic [XLEN-1:0]   res_sel;

   assign prod_f = neg_q ? -acc_q : acc_q;
   assign quo_f  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   assign rem_f  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

   always_comb begin
      res_sel = '0;
      case (op_q)
         OP_DIVU, OP_DIV:             res_sel = bzero_q ? '0 : quo_f;
         OP_REMU, OP_REM:             res_sel = bzero_q ? '0 : rem_f;
         OP_MUL:                      res_sel = prod_f[XLEN-1:0];
         OP_MULHU, OP_MULHSU, OP_MULH: res_sel = prod_f[2*XLEN-1:XLEN];
         default:                     res_sel = '0;
      endcase
   end

   // ---------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = S_CALC;
         S_CALC: if (last_iter) state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath and registered outputs
   // ---------------------------------------------------------------
   // busy/done are registered one cycle behind the state, so busy covers
   // the cycles after E1..E32 and done lands after E33 together with result.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q     <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         bzero_q  <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         busy_q <= (state == S_CALC);
         done_q <= (state == S_DONE);
         if (accept) begin
            op_q    <= bus.alu_ctl;
            opnd_q  <= is_mul_in ? mag_a : mag_b;
            acc_q   <= {{XLEN{1'b0}}, (is_mul_in ? mag_b : mag_a)};
            neg_q   <= neg_in;
            bzero_q <= (bus.b == '0);
            cnt_q   <= '0;
         end else if (state == S_CALC) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 6'd1;
         end
         if (state == S_DONE) begin
            result_q <= res_sel;
         end
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.zero   = (result_q == '0);

endmodule
